// File: rtl/serial_multi.sv
// SPI-style serial master: shifts BITS-wide words out on out_serial while assembling the
// word arriving on in_serial, with configurable clock polarity/phase, bit order and chip select.
module serial_multi #(
    parameter int BITS          = 8,
    parameter int LOWBIT_FIRST  = 0,
    parameter int MAIN_CLK_HZ   = 50_000_000,
    parameter int SERIAL_CLK_HZ = 10_000_000,
    parameter int CPOL          = 1,
    parameter int CPHA          = 0,
    parameter int NUM_CS        = 1,
    parameter int CS_ACTIVE     = 0,
    localparam int CSW          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_enable,
    input  logic [CSW-1:0]    in_cs_sel,
    input  logic [BITS-1:0]   in_parallel,
    input  logic              in_serial,
    output logic              out_serial,
    output logic              out_clk,
    output logic [NUM_CS-1:0] out_cs,
    output logic              out_ready,
    output logic              out_next_word,
    output logic [BITS-1:0]   out_parallel,
    output logic              out_word_valid
);

    localparam int HALF = MAIN_CLK_HZ / (2 * SERIAL_CLK_HZ);
    localparam int CNTW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int HCW  = $clog2(2 * BITS);

    localparam logic [CNTW-1:0]   HALF_LAST   = CNTW'(HALF - 1);
    localparam logic [HCW-1:0]    HC_LAST     = HCW'(2 * BITS - 1);
    localparam logic [HCW-1:0]    SAMPLE_LAST = HCW'((CPHA != 0) ? (2 * BITS - 1) : (2 * BITS - 2));
    localparam logic              CLK_IDLE    = (CPOL != 0);
    localparam logic              CS_ON       = (CS_ACTIVE != 0);
    localparam logic [NUM_CS-1:0] CS_OFF      = {NUM_CS{~CS_ON}};
    localparam logic [CSW:0]      NUM_CS_W    = (CSW + 1)'(NUM_CS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t             state_r, state_nx;
    logic [CNTW-1:0]    cnt_r;
    logic [HCW-1:0]     hc_r;
    logic [BITS-1:0]    tx_r, rx_r, rx_next_s;
    logic [BITS-1:0]    out_parallel_r;
    logic [NUM_CS-1:0]  out_cs_r;
    logic [CSW-1:0]     sel_s;
    logic               out_serial_r, out_clk_r, out_ready_r, out_next_word_r, out_word_valid_r;
    logic               tick_s, xfer_tick_s, start_s, reload_s, drop_s;
    logic               lead_s, trail_s, sample_s, shift_s, last_s;

    function automatic logic first_bit(input logic [BITS-1:0] w);
        if (LOWBIT_FIRST != 0) first_bit = w[0];
        else                   first_bit = w[BITS-1];
    endfunction

    function automatic logic [BITS-1:0] shift_tx(input logic [BITS-1:0] w);
        if (LOWBIT_FIRST != 0) shift_tx = {1'b0, w[BITS-1:1]};
        else                   shift_tx = {w[BITS-2:0], 1'b0};
    endfunction

    // RX assembly mirrors the TX order so a loopback returns the same word
    function automatic logic [BITS-1:0] rx_in(input logic [BITS-1:0] w, input logic b);
        if (LOWBIT_FIRST != 0) rx_in = {b, w[BITS-1:1]};
        else                   rx_in = {w[BITS-2:0], b};
    endfunction

    function automatic logic [NUM_CS-1:0] cs_vec(input logic [CSW-1:0] idx);
        for (int i = 0; i < NUM_CS; i++) begin
            cs_vec[i] = (CSW'(i) == idx) ? CS_ON : ~CS_ON;
        end
    endfunction

    // State register
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) state_r <= ST_IDLE;
        else         state_r <= state_nx;
    end

    // Next-state logic and transition strobes
    always_comb begin
        tick_s      = (state_r != ST_IDLE) && (cnt_r == HALF_LAST);
        xfer_tick_s = (state_r == ST_TRANSFER) && tick_s;
        start_s     = 1'b0;
        reload_s    = 1'b0;
        drop_s      = 1'b0;
        state_nx    = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_enable) begin
                    state_nx = ST_SETUP;
                    start_s  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tick_s) state_nx = ST_TRANSFER;
                else        state_nx = ST_SETUP;
            end
            ST_TRANSFER: begin
                if (tick_s && (hc_r == HC_LAST)) state_nx = ST_HOLD;
                else                             state_nx = ST_TRANSFER;
            end
            ST_HOLD: begin
                if (tick_s && in_enable) begin
                    state_nx = ST_TRANSFER;
                    reload_s = 1'b1;
                end else if (tick_s) begin
                    state_nx = ST_IDLE;
                    drop_s   = 1'b1;
                end else begin
                    state_nx = ST_HOLD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Edge classification: even tick counts are leading edges, odd ones trailing
    always_comb begin
        lead_s  = xfer_tick_s && !hc_r[0];
        trail_s = xfer_tick_s && hc_r[0];
        if (CPHA != 0) begin
            sample_s = trail_s;
            shift_s  = lead_s;
        end else begin
            sample_s = lead_s;
            shift_s  = trail_s && (hc_r != HC_LAST);
        end
        last_s    = sample_s && (hc_r == SAMPLE_LAST);
        rx_next_s = rx_in(rx_r, in_serial);
        if ({1'b0, in_cs_sel} >= NUM_CS_W) sel_s = {CSW{1'b0}};
        else                               sel_s = in_cs_sel;
    end

    // Half-period counter, restarted whenever the state changes
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt_r <= {CNTW{1'b0}};
        end else if ((state_nx != state_r) || tick_s || (state_r == ST_IDLE)) begin
            cnt_r <= {CNTW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNTW'(1);
        end
    end

    // Shift registers, serial clock and registered outputs
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            hc_r             <= {HCW{1'b0}};
            tx_r             <= {BITS{1'b0}};
            rx_r             <= {BITS{1'b0}};
            out_parallel_r   <= {BITS{1'b0}};
            out_serial_r     <= 1'b0;
            out_clk_r        <= CLK_IDLE;
            out_cs_r         <= CS_OFF;
            out_ready_r      <= 1'b1;
            out_next_word_r  <= 1'b0;
            out_word_valid_r <= 1'b0;
        end else begin
            out_ready_r      <= (state_nx == ST_IDLE);
            out_next_word_r  <= start_s | reload_s;
            out_word_valid_r <= last_s;
            if (start_s)     out_cs_r <= cs_vec(sel_s);
            else if (drop_s) out_cs_r <= CS_OFF;
            if (start_s || reload_s) begin
                hc_r <= {HCW{1'b0}};
                if (CPHA != 0) begin
                    tx_r <= in_parallel;
                end else begin
                    out_serial_r <= first_bit(in_parallel);
                    tx_r         <= shift_tx(in_parallel);
                end
            end else if (xfer_tick_s) begin
                hc_r      <= hc_r + HCW'(1);
                out_clk_r <= ~out_clk_r;
                if (shift_s) begin
                    out_serial_r <= first_bit(tx_r);
                    tx_r         <= shift_tx(tx_r);
                end
            end
            if (sample_s) rx_r <= rx_next_s;
            if (last_s)   out_parallel_r <= rx_next_s;
        end
    end

    assign out_serial     = out_serial_r;
    assign out_clk        = out_clk_r;
    assign out_cs         = out_cs_r;
    assign out_ready      = out_ready_r;
    assign out_next_word  = out_next_word_r;
    assign out_parallel   = out_parallel_r;
    assign out_word_valid = out_word_valid_r;

endmodule

// File: tb/tb_serial_multi.sv
// Directed bench for serial_multi: loopback vectors across bit order, CPOL/CPHA,
// chip-select handling, burst timing and asynchronous reset.
module tb_serial_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [6:0]      en;
    logic [7:0]      par;
    logic [1:0]      sel;
    logic [6:0]      ser, clk_o, rdy, nw, wv;
    logic [6:0][7:0] opar;
    logic [4:0]      cs1;
    logic [3:0]      cs4;
    logic [2:0]      cs3;

    int errors = 0;
    int checks = 0;

    // u0..u4: {CPOL,CPHA,LSB-first} = {1,0,0} {1,0,1} {0,0,0} {0,1,0} {1,1,0}
    localparam logic [4:0] POL  = 5'b10011;
    localparam logic [4:0] PHA  = 5'b11000;
    localparam logic [4:0] LSBF = 5'b00010;

    for (genvar g = 0; g < 5; g++) begin : g_std
        serial_multi #(
            .BITS(8), .LOWBIT_FIRST(LSBF[g] ? 1 : 0),
            .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(250_000),
            .CPOL(POL[g] ? 1 : 0), .CPHA(PHA[g] ? 1 : 0),
            .NUM_CS(1), .CS_ACTIVE(0)
        ) u_dut (
            .in_clk(clk), .in_rst(rst), .in_enable(en[g]), .in_cs_sel(sel[0]),
            .in_parallel(par), .in_serial(ser[g]), .out_serial(ser[g]),
            .out_clk(clk_o[g]), .out_cs(cs1[g]), .out_ready(rdy[g]),
            .out_next_word(nw[g]), .out_parallel(opar[g]), .out_word_valid(wv[g])
        );
    end

    serial_multi #(
        .BITS(8), .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(250_000), .NUM_CS(4)
    ) u_cs4 (
        .in_clk(clk), .in_rst(rst), .in_enable(en[5]), .in_cs_sel(sel),
        .in_parallel(par), .in_serial(ser[5]), .out_serial(ser[5]),
        .out_clk(clk_o[5]), .out_cs(cs4), .out_ready(rdy[5]),
        .out_next_word(nw[5]), .out_parallel(opar[5]), .out_word_valid(wv[5])
    );

    serial_multi #(
        .BITS(8), .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(250_000), .NUM_CS(3)
    ) u_cs3 (
        .in_clk(clk), .in_rst(rst), .in_enable(en[6]), .in_cs_sel(sel),
        .in_parallel(par), .in_serial(ser[6]), .out_serial(ser[6]),
        .out_clk(clk_o[6]), .out_cs(cs3), .out_ready(rdy[6]),
        .out_next_word(nw[6]), .out_parallel(opar[6]), .out_word_valid(wv[6])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One word with enable dropped right after the capture pulse
    task automatic one_word(input int k, input logic [7:0] d, output logic [7:0] got, output int wvc);
        int n;
        par   = d;
        en[k] = 1'b1;
        n     = 0;
        while (!nw[k] && n < 20) begin cyc(); n++; end
        en[k] = 1'b0;
        chk("next_word_seen", nw[k], 1);
        wvc = 0;
        got = 8'h00;
        n   = 0;
        while (!rdy[k] && n < 200) begin
            cyc();
            n++;
            if (wv[k]) begin wvc++; got = opar[k]; end
        end
        chk("back_to_idle", rdy[k], 1);
    endtask

    // Like one_word, but records out_serial at each falling (leading, CPOL=1) out_clk edge
    task automatic obs_word(input int k, input logic [7:0] d, output logic [7:0] bits,
                            output int pulses, output int gap_bad, output int wvc, output logic [7:0] got);
        int n, last_edge;
        logic prev;
        par   = d;
        en[k] = 1'b1;
        n     = 0;
        while (!nw[k] && n < 20) begin cyc(); n++; end
        en[k] = 1'b0;
        chk("obs_next_word", nw[k], 1);
        bits = 8'h00; pulses = 0; gap_bad = 0; wvc = 0; got = 8'h00;
        last_edge = -1;
        prev = clk_o[k];
        n = 0;
        while (!rdy[k] && n < 200) begin
            cyc();
            n++;
            if (prev && !clk_o[k]) begin
                if (pulses < 8) bits[7 - pulses] = ser[k];
                if (last_edge >= 0 && (n - last_edge) != 4) gap_bad++;
                last_edge = n;
                pulses++;
            end
            if (wv[k]) begin wvc++; got = opar[k]; end
            prev = clk_o[k];
        end
        chk("obs_idle", rdy[k], 1);
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [7:0] exp_par;
        logic       exp_idle;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] got, bits;
    logic [7:0] seq [3];
    int         wvc, pulses, gap_bad, nwc, cs_bad, n;
    int         nw_t [3];
    int         wv_t [3];

    initial begin
        tbl[0] = '{0, 8'h3C, 8'h3C, 1'b1};
        tbl[1] = '{2, 8'h3C, 8'h3C, 1'b0};
        tbl[2] = '{3, 8'h3C, 8'h3C, 1'b0};
        tbl[3] = '{4, 8'h3C, 8'h3C, 1'b1};
        tbl[4] = '{1, 8'h01, 8'h01, 1'b1};
        tbl[5] = '{3, 8'h81, 8'h81, 1'b0};
        tbl[6] = '{4, 8'h5A, 8'h5A, 1'b1};
        tbl[7] = '{1, 8'hC6, 8'hC6, 1'b1};

        rst = 1'b0; en = 7'h00; par = 8'h00; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy, 7'h7F);
        chk("rst_clk_idle", clk_o, 7'b1110011);
        chk("rst_cs1", cs1, 5'b11111);
        chk("rst_cs4", cs4, 4'hF);
        chk("rst_cs3", cs3, 3'h7);
        chk("rst_par0", opar[0], 8'h00);
        chk("rst_ser", ser, 7'h00);
        rst = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            one_word(tbl[i].k, tbl[i].d, got, wvc);
            chk("loop_par", got, tbl[i].exp_par);
            chk("loop_wv_once", wvc, 1);
            chk("loop_clk_idle", clk_o[tbl[i].k], tbl[i].exp_idle);
            cyc();
        end

        obs_word(0, 8'hA5, bits, pulses, gap_bad, wvc, got);
        chk("a5_bits", bits, 8'hA5);
        chk("a5_pulses", pulses, 8);
        chk("a5_gap", gap_bad, 0);
        chk("a5_wv_once", wvc, 1);
        chk("a5_par", got, 8'hA5);
        chk("a5_clk_idle", clk_o[0], 1);
        cyc();

        obs_word(1, 8'h01, bits, pulses, gap_bad, wvc, got);
        chk("lsb_bits", bits, 8'h80);
        chk("lsb_par", got, 8'h01);
        cyc();

        // Burst of three words with enable dropped after the third capture
        par = 8'h01; en[0] = 1'b1; nwc = 0; wvc = 0; cs_bad = 0;
        for (int j = 0; j < 3; j++) begin nw_t[j] = 0; wv_t[j] = 0; seq[j] = 8'h00; end
        for (int c = 0; c < 300; c++) begin
            cyc();
            if (nw[0]) begin
                if (nwc < 3) nw_t[nwc] = c;
                nwc++;
                if (nwc == 1)      par = 8'h80;
                else if (nwc == 2) par = 8'hFF;
                else               en[0] = 1'b0;
            end
            if (wv[0]) begin
                if (wvc < 3) begin wv_t[wvc] = c; seq[wvc] = opar[0]; end
                wvc++;
            end
            if (nwc >= 1 && wvc < 3 && cs1[0] !== 1'b0) cs_bad++;
            if (rdy[0] && nwc > 0) break;
        end
        chk("burst_nw_count", nwc, 3);
        chk("burst_wv_count", wvc, 3);
        chk("burst_par0", seq[0], 8'h01);
        chk("burst_par1", seq[1], 8'h80);
        chk("burst_par2", seq[2], 8'hFF);
        chk("burst_nw_period", nw_t[2] - nw_t[1], 34);
        chk("burst_wv_period01", wv_t[1] - wv_t[0], 34);
        chk("burst_wv_period12", wv_t[2] - wv_t[1], 34);
        chk("burst_cs_steady", cs_bad, 0);
        chk("burst_idle", rdy[0], 1);
        chk("burst_cs_off", cs1[0], 1);
        cyc();

        // Chip select latched at start; mid-word change ignored
        sel = 2'd2; par = 8'h77; en[5] = 1'b1; n = 0;
        while (!nw[5] && n < 20) begin cyc(); n++; end
        en[5] = 1'b0; sel = 2'd1;
        chk("cs4_start", cs4, 4'b1011);
        cs_bad = 0; n = 0;
        while (!rdy[5] && n < 200) begin
            cyc();
            n++;
            if (!rdy[5] && cs4 !== 4'b1011) cs_bad++;
        end
        chk("cs4_steady", cs_bad, 0);
        chk("cs4_off", cs4, 4'hF);

        sel = 2'd3; en[6] = 1'b1; n = 0;
        while (!nw[6] && n < 20) begin cyc(); n++; end
        en[6] = 1'b0;
        chk("cs3_out_of_range", cs3, 3'b110);
        n = 0;
        while (!rdy[6] && n < 200) begin cyc(); n++; end
        chk("cs3_off", cs3, 3'h7);
        sel = 2'd0;

        // Reset in the middle of a word
        par = 8'h3C; en[0] = 1'b1; n = 0;
        while (!nw[0] && n < 20) begin cyc(); n++; end
        en[0] = 1'b0;
        repeat (10) cyc();
        chk("mid_busy", rdy[0], 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_cs", cs1[0], 1);
        chk("mid_rst_clk", clk_o[0], 1);
        chk("mid_rst_ready", rdy[0], 1);
        chk("mid_rst_par", opar[0], 8'h00);
        chk("mid_rst_ser", ser[0], 0);
        cyc();
        cyc();
        rst = 1'b1; en[0] = 1'b1;
        cyc();
        chk("enable_after_reset", nw[0], 1);
        en[0] = 1'b0;
        n = 0;
        while (!rdy[0] && n < 200) begin cyc(); n++; end
        chk("final_idle", rdy[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
